// File: rtl/aq_mmu_utlb_array.sv
// aq_mmu_utlb_array
// Fully associative micro-TLB with Sv39 page-size matching, ASID/global tagging,
// flush handling and a refill state machine toward the joint TLB.
// Ports:
//   utlb_entry_clk, cpurst_b          clock, async active-low reset
//   cp0_mach_mode, cp0_asid,
//   regs_mmu_en                       current translation context
//   utlb_req_vld/vpn -> utlb_hit_*    zero-cycle lookup, zero data on miss
//   utlb_refill_req/vpn, jtlb_*       refill handshake toward the jTLB
//   utlb_refill_fault                 one-cycle pulse on a non-aborted error response
//   utlb_busy                         refill in progress
//   flush_all/asid_req/va_req/va      invalidation requests
module aq_mmu_utlb_array #(
    parameter int unsigned ENTRY_NUM  = 4,
    parameter int unsigned VPN_WIDTH  = 27,
    parameter int unsigned PPN_WIDTH  = 28,
    parameter int unsigned FLG_WIDTH  = 15,
    parameter int unsigned ASID_WIDTH = 16
) (
    input  logic                  utlb_entry_clk,
    input  logic                  cpurst_b,
    input  logic                  cp0_mach_mode,
    input  logic [ASID_WIDTH-1:0] cp0_asid,
    input  logic                  regs_mmu_en,
    input  logic                  utlb_req_vld,
    input  logic [VPN_WIDTH-1:0]  utlb_req_vpn,
    output logic                  utlb_hit,
    output logic [PPN_WIDTH-1:0]  utlb_hit_ppn,
    output logic [2:0]            utlb_hit_pgs,
    output logic [FLG_WIDTH-1:0]  utlb_hit_flg,
    output logic                  utlb_refill_req,
    output logic [VPN_WIDTH-1:0]  utlb_refill_vpn,
    input  logic                  jtlb_refill_gnt,
    input  logic                  jtlb_refill_vld,
    input  logic                  jtlb_refill_err,
    input  logic [PPN_WIDTH-1:0]  jtlb_refill_ppn,
    input  logic [2:0]            jtlb_refill_pgs,
    input  logic [FLG_WIDTH-1:0]  jtlb_refill_flg,
    output logic                  utlb_refill_fault,
    output logic                  utlb_busy,
    input  logic                  flush_all,
    input  logic                  flush_asid_req,
    input  logic                  flush_va_req,
    input  logic [VPN_WIDTH-1:0]  flush_va
);

    localparam int unsigned IdxW = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e                state_q, state_d;
    logic [ENTRY_NUM-1:0]  vld_q, vld_d;
    logic [VPN_WIDTH-1:0]  vpn_q    [ENTRY_NUM];
    logic [VPN_WIDTH-1:0]  vpn_d    [ENTRY_NUM];
    logic [2:0]            pgs_q    [ENTRY_NUM];
    logic [2:0]            pgs_d    [ENTRY_NUM];
    logic [PPN_WIDTH-1:0]  ppn_q    [ENTRY_NUM];
    logic [PPN_WIDTH-1:0]  ppn_d    [ENTRY_NUM];
    logic [FLG_WIDTH-1:0]  flg_q    [ENTRY_NUM];
    logic [FLG_WIDTH-1:0]  flg_d    [ENTRY_NUM];
    logic [ASID_WIDTH-1:0] asid_q   [ENTRY_NUM];
    logic [ASID_WIDTH-1:0] asid_d   [ENTRY_NUM];
    logic [ENTRY_NUM-1:0]  mmu_on_q, mmu_on_d;
    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [VPN_WIDTH-1:0]  refill_vpn_q, refill_vpn_d;
    logic [ASID_WIDTH-1:0] refill_asid_q, refill_asid_d;
    logic                  abort_q, abort_d;
    logic                  fault_q, fault_d;

    logic [ENTRY_NUM-1:0]  hit_vec, flush_vec;
    logic [IdxW-1:0]       hit_idx, victim_idx;
    logic                  victim_from_rr;
    logic                  flush_any;
    logic                  fill;

    // Page-size-masked VPN compare; an illegal (non one-hot) size never matches.
    function automatic logic vpn_match(input logic [2:0]           pgs,
                                       input logic [VPN_WIDTH-1:0] a,
                                       input logic [VPN_WIDTH-1:0] b);
        case (pgs)
            3'b001:  return a == b;
            3'b010:  return a[VPN_WIDTH-1:9] == b[VPN_WIDTH-1:9];
            3'b100:  return a[VPN_WIDTH-1:18] == b[VPN_WIDTH-1:18];
            default: return 1'b0;
        endcase
    endfunction

    assign flush_any = flush_all | flush_asid_req | flush_va_req;

    always_comb begin
        hit_vec   = '0;
        flush_vec = '0;
        for (int i = 0; i < int'(ENTRY_NUM); i++) begin
            hit_vec[i] = vld_q[i] & vpn_match(pgs_q[i], vpn_q[i], utlb_req_vpn)
                       & (flg_q[i][5] | (asid_q[i] == cp0_asid))
                       & (flg_q[i][10] == cp0_mach_mode)
                       & (cp0_mach_mode | (mmu_on_q[i] == regs_mmu_en));
            flush_vec[i] = flush_all
                         | (flush_asid_req & ~flg_q[i][5] & (asid_q[i] == cp0_asid))
                         | (flush_va_req & vpn_match(pgs_q[i], vpn_q[i], flush_va));
        end
    end

    // Downward scans so the lowest index wins.
    always_comb begin
        hit_idx        = '0;
        victim_idx     = rr_ptr_q;
        victim_from_rr = 1'b1;
        for (int i = int'(ENTRY_NUM) - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_idx = IdxW'(i);
            end
            if (!vld_q[i]) begin
                victim_idx     = IdxW'(i);
                victim_from_rr = 1'b0;
            end
        end
    end

    always_comb begin
        utlb_hit     = utlb_req_vld & (|hit_vec);
        utlb_hit_ppn = '0;
        utlb_hit_pgs = '0;
        utlb_hit_flg = '0;
        if (utlb_hit) begin
            utlb_hit_ppn = ppn_q[hit_idx];
            utlb_hit_pgs = pgs_q[hit_idx];
            utlb_hit_flg = flg_q[hit_idx];
        end
    end

    // Refill FSM. A flush arriving in the response cycle is treated like an earlier abort.
    always_comb begin
        state_d       = state_q;
        refill_vpn_d  = refill_vpn_q;
        refill_asid_d = refill_asid_q;
        abort_d       = abort_q;
        fault_d       = 1'b0;
        fill          = 1'b0;
        case (state_q)
            StIdle: begin
                if (utlb_req_vld && !utlb_hit && !flush_any) begin
                    refill_vpn_d  = utlb_req_vpn;
                    refill_asid_d = cp0_asid;
                    abort_d       = 1'b0;
                    state_d       = StReq;
                end
            end
            StReq: begin
                if (flush_any) abort_d = 1'b1;
                if (jtlb_refill_gnt) state_d = StWait;
            end
            StWait: begin
                if (flush_any) abort_d = 1'b1;
                if (jtlb_refill_vld) begin
                    state_d = StIdle;
                    if (!abort_q && !flush_any) begin
                        if (jtlb_refill_err) fault_d = 1'b1;
                        else                 fill    = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vld_d    = vld_q & ~flush_vec;
        vpn_d    = vpn_q;
        pgs_d    = pgs_q;
        ppn_d    = ppn_q;
        flg_d    = flg_q;
        asid_d   = asid_q;
        mmu_on_d = mmu_on_q;
        rr_ptr_d = rr_ptr_q;
        if (fill) begin
            vld_d[victim_idx]    = 1'b1;
            vpn_d[victim_idx]    = refill_vpn_q;
            pgs_d[victim_idx]    = jtlb_refill_pgs;
            ppn_d[victim_idx]    = jtlb_refill_ppn;
            flg_d[victim_idx]    = jtlb_refill_flg;
            asid_d[victim_idx]   = refill_asid_q;
            mmu_on_d[victim_idx] = regs_mmu_en;
            if (victim_from_rr) begin
                rr_ptr_d = (rr_ptr_q == IdxW'(ENTRY_NUM - 1)) ? '0 : rr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q       <= StIdle;
            vld_q         <= '0;
            vpn_q         <= '{default: '0};
            pgs_q         <= '{default: '0};
            ppn_q         <= '{default: '0};
            flg_q         <= '{default: '0};
            asid_q        <= '{default: '0};
            mmu_on_q      <= '0;
            rr_ptr_q      <= '0;
            refill_vpn_q  <= '0;
            refill_asid_q <= '0;
            abort_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            vld_q         <= vld_d;
            vpn_q         <= vpn_d;
            pgs_q         <= pgs_d;
            ppn_q         <= ppn_d;
            flg_q         <= flg_d;
            asid_q        <= asid_d;
            mmu_on_q      <= mmu_on_d;
            rr_ptr_q      <= rr_ptr_d;
            refill_vpn_q  <= refill_vpn_d;
            refill_asid_q <= refill_asid_d;
            abort_q       <= abort_d;
            fault_q       <= fault_d;
        end
    end

    assign utlb_refill_req   = (state_q == StReq);
    assign utlb_refill_vpn   = refill_vpn_q;
    assign utlb_refill_fault = fault_q;
    assign utlb_busy         = (state_q != StIdle);

endmodule

// File: tb/tb_aq_mmu_utlb_array.sv
// Self-checking bench for aq_mmu_utlb_array: lookup expectations go through a scoreboard
// queue, refill handshake and flush behaviour are checked directly.
module tb_aq_mmu_utlb_array;

    localparam int unsigned ENTRY_NUM = 4;

    logic        clk;
    logic        cpurst_b;
    logic        cp0_mach_mode;
    logic [15:0] cp0_asid;
    logic        regs_mmu_en;
    logic        utlb_req_vld;
    logic [26:0] utlb_req_vpn;
    logic        utlb_hit;
    logic [27:0] utlb_hit_ppn;
    logic [2:0]  utlb_hit_pgs;
    logic [14:0] utlb_hit_flg;
    logic        utlb_refill_req;
    logic [26:0] utlb_refill_vpn;
    logic        jtlb_refill_gnt;
    logic        jtlb_refill_vld;
    logic        jtlb_refill_err;
    logic [27:0] jtlb_refill_ppn;
    logic [2:0]  jtlb_refill_pgs;
    logic [14:0] jtlb_refill_flg;
    logic        utlb_refill_fault;
    logic        utlb_busy;
    logic        flush_all;
    logic        flush_asid_req;
    logic        flush_va_req;
    logic [26:0] flush_va;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic        hit;
        logic [27:0] ppn;
        logic [2:0]  pgs;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [14:0] FlgNg = 15'h00C7;  // non-global, user-mode tag
    localparam logic [14:0] FlgG  = 15'h00E7;  // global

    aq_mmu_utlb_array #(.ENTRY_NUM(ENTRY_NUM)) dut (
        .utlb_entry_clk   (clk),
        .cpurst_b         (cpurst_b),
        .cp0_mach_mode    (cp0_mach_mode),
        .cp0_asid         (cp0_asid),
        .regs_mmu_en      (regs_mmu_en),
        .utlb_req_vld     (utlb_req_vld),
        .utlb_req_vpn     (utlb_req_vpn),
        .utlb_hit         (utlb_hit),
        .utlb_hit_ppn     (utlb_hit_ppn),
        .utlb_hit_pgs     (utlb_hit_pgs),
        .utlb_hit_flg     (utlb_hit_flg),
        .utlb_refill_req  (utlb_refill_req),
        .utlb_refill_vpn  (utlb_refill_vpn),
        .jtlb_refill_gnt  (jtlb_refill_gnt),
        .jtlb_refill_vld  (jtlb_refill_vld),
        .jtlb_refill_err  (jtlb_refill_err),
        .jtlb_refill_ppn  (jtlb_refill_ppn),
        .jtlb_refill_pgs  (jtlb_refill_pgs),
        .jtlb_refill_flg  (jtlb_refill_flg),
        .utlb_refill_fault(utlb_refill_fault),
        .utlb_busy        (utlb_busy),
        .flush_all        (flush_all),
        .flush_asid_req   (flush_asid_req),
        .flush_va_req     (flush_va_req),
        .flush_va         (flush_va)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one lookup for half a cycle; dropped before the edge so a miss starts no refill.
    task automatic lookup(input string tag, input logic [26:0] vpn, input logic h,
                          input logic [27:0] ppn, input logic [2:0] pgs);
        exp_t e;
        @(negedge clk);
        utlb_req_vld = 1'b1;
        utlb_req_vpn = vpn;
        e.tag = tag;
        e.hit = h;
        e.ppn = h ? ppn : '0;
        e.pgs = h ? pgs : '0;
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        check_eq({e.tag, ".hit"}, 64'(utlb_hit), 64'(e.hit));
        check_eq({e.tag, ".ppn"}, 64'(utlb_hit_ppn), 64'(e.ppn));
        check_eq({e.tag, ".pgs"}, 64'(utlb_hit_pgs), 64'(e.pgs));
        utlb_req_vld = 1'b0;
    endtask

    // Full miss/refill sequence: miss, gnt one cycle later, vld one cycle after that.
    // abort inserts a flush_all cycle inside WAIT before the response.
    task automatic refill(input string tag, input logic [26:0] vpn, input logic [27:0] ppn,
                          input logic [2:0] pgs, input logic [14:0] flg,
                          input logic err, input logic abort);
        @(negedge clk);
        utlb_req_vld = 1'b1;
        utlb_req_vpn = vpn;
        #1;
        check_eq({tag, ".miss"}, 64'(utlb_hit), 64'd0);
        @(negedge clk);
        utlb_req_vld = 1'b0;
        #1;
        check_eq({tag, ".req"}, 64'(utlb_refill_req), 64'd1);
        check_eq({tag, ".rvpn"}, 64'(utlb_refill_vpn), 64'(vpn));
        jtlb_refill_gnt = 1'b1;
        @(negedge clk);
        jtlb_refill_gnt = 1'b0;
        #1;
        check_eq({tag, ".req_drop"}, 64'(utlb_refill_req), 64'd0);
        check_eq({tag, ".busy"}, 64'(utlb_busy), 64'd1);
        if (abort) begin
            flush_all = 1'b1;
            @(negedge clk);
            flush_all = 1'b0;
        end
        jtlb_refill_vld = 1'b1;
        jtlb_refill_err = err;
        jtlb_refill_ppn = ppn;
        jtlb_refill_pgs = pgs;
        jtlb_refill_flg = flg;
        @(negedge clk);
        jtlb_refill_vld = 1'b0;
        jtlb_refill_err = 1'b0;
        #1;
        check_eq({tag, ".idle"}, 64'(utlb_busy), 64'd0);
        check_eq({tag, ".fault"}, 64'(utlb_refill_fault), 64'(err & ~abort));
        @(negedge clk);
        #1;
        check_eq({tag, ".fault_end"}, 64'(utlb_refill_fault), 64'd0);
    endtask

    task automatic pulse_flush(input logic all, input logic asid, input logic va,
                               input logic [26:0] fva);
        @(negedge clk);
        flush_all      = all;
        flush_asid_req = asid;
        flush_va_req   = va;
        flush_va       = fva;
        @(negedge clk);
        flush_all      = 1'b0;
        flush_asid_req = 1'b0;
        flush_va_req   = 1'b0;
    endtask

    initial begin
        cpurst_b        = 1'b0;
        cp0_mach_mode   = 1'b0;
        cp0_asid        = 16'h0005;
        regs_mmu_en     = 1'b1;
        utlb_req_vld    = 1'b0;
        utlb_req_vpn    = '0;
        jtlb_refill_gnt = 1'b0;
        jtlb_refill_vld = 1'b0;
        jtlb_refill_err = 1'b0;
        jtlb_refill_ppn = '0;
        jtlb_refill_pgs = '0;
        jtlb_refill_flg = '0;
        flush_all       = 1'b0;
        flush_asid_req  = 1'b0;
        flush_va_req    = 1'b0;
        flush_va        = '0;
        #12;
        check_eq("rst.req", 64'(utlb_refill_req), 64'd0);
        check_eq("rst.busy", 64'(utlb_busy), 64'd0);
        check_eq("rst.fault", 64'(utlb_refill_fault), 64'd0);
        check_eq("rst.rvpn", 64'(utlb_refill_vpn), 64'd0);
        @(negedge clk);
        cpurst_b = 1'b1;
        lookup("rst.lookup", 27'h1234567, 1'b0, '0, '0);

        // 4K, 2M and 1G fills land in entries 0..2
        refill("f4k", 27'h1234567, 28'h00ABCDE, 3'b001, FlgNg, 1'b0, 1'b0);
        lookup("hit4k", 27'h1234567, 1'b1, 28'h00ABCDE, 3'b001);
        lookup("miss4k_nb", 27'h1234568, 1'b0, '0, '0);
        refill("f2m", 27'h1555000, 28'h0222200, 3'b010, FlgNg, 1'b0, 1'b0);
        lookup("hit2m", 27'h15550FF, 1'b1, 28'h0222200, 3'b010);
        refill("f1g", 27'h4C00000, 28'h0333000, 3'b100, FlgNg, 1'b0, 1'b0);
        lookup("hit1g", 27'h4C3FFFF, 1'b1, 28'h0333000, 3'b100);
        refill("f3", 27'h0000100, 28'h0000011, 3'b001, FlgNg, 1'b0, 1'b0);

        // All valid: replacements go to entry 0, then 1, then 2
        refill("rr0", 27'h0000200, 28'h0000022, 3'b001, FlgNg, 1'b0, 1'b0);
        refill("rr1", 27'h0000300, 28'h0000033, 3'b001, FlgNg, 1'b0, 1'b0);
        lookup("rr.old4k", 27'h1234567, 1'b0, '0, '0);
        lookup("rr.old2m", 27'h15550FF, 1'b0, '0, '0);
        lookup("rr.keep1g", 27'h4C3FFFF, 1'b1, 28'h0333000, 3'b100);
        lookup("rr.new0", 27'h0000200, 1'b1, 28'h0000022, 3'b001);
        lookup("rr.new1", 27'h0000300, 1'b1, 28'h0000033, 3'b001);
        refill("rr2", 27'h0000400, 28'h0000044, 3'b001, FlgNg, 1'b0, 1'b0);
        lookup("rr2.gone1g", 27'h4C3FFFF, 1'b0, '0, '0);
        lookup("rr2.keep3", 27'h0000100, 1'b1, 28'h0000011, 3'b001);

        pulse_flush(1'b1, 1'b0, 1'b0, '0);
        lookup("fall.miss", 27'h0000100, 1'b0, '0, '0);

        // ASID tagging and ASID flush
        refill("fg", 27'h0000500, 28'h0000055, 3'b001, FlgG, 1'b0, 1'b0);
        refill("fng", 27'h0000600, 28'h0000066, 3'b001, FlgNg, 1'b0, 1'b0);
        cp0_asid = 16'h0007;
        lookup("asid.g", 27'h0000500, 1'b1, 28'h0000055, 3'b001);
        lookup("asid.ng", 27'h0000600, 1'b0, '0, '0);
        cp0_asid = 16'h0005;
        lookup("asid.ng_back", 27'h0000600, 1'b1, 28'h0000066, 3'b001);
        pulse_flush(1'b0, 1'b1, 1'b0, '0);
        lookup("fasid.g", 27'h0000500, 1'b1, 28'h0000055, 3'b001);
        lookup("fasid.ng", 27'h0000600, 1'b0, '0, '0);

        // VA flush of a 2M page through an interior VPN
        refill("f2m_b", 27'h1555000, 28'h0777700, 3'b010, FlgNg, 1'b0, 1'b0);
        lookup("f2m_b.hit", 27'h15551AB, 1'b1, 28'h0777700, 3'b010);
        pulse_flush(1'b0, 1'b0, 1'b1, 27'h15550AA);
        lookup("fva.2m", 27'h15551AB, 1'b0, '0, '0);
        lookup("fva.keep", 27'h0000500, 1'b1, 28'h0000055, 3'b001);

        // Flush during WAIT discards the response; error response faults without a write
        refill("abort", 27'h0000700, 28'h0000077, 3'b001, FlgNg, 1'b0, 1'b1);
        lookup("abort.nowr", 27'h0000700, 1'b0, '0, '0);
        refill("err", 27'h0000800, 28'h0000088, 3'b001, FlgNg, 1'b1, 1'b0);
        lookup("err.nowr", 27'h0000800, 1'b0, '0, '0);
        refill("after", 27'h0000900, 28'h0000099, 3'b001, FlgNg, 1'b0, 1'b0);
        lookup("after.hit", 27'h0000900, 1'b1, 28'h0000099, 3'b001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
